fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 25 ++
 rtl/fetch_sequencer_if.sv | 33 +++
 rtl/fetch_sequencer_pc_counter.sv | 39 +++
 rtl/fetch_sequencer.sv | 103 ++++++++++
 tb/tb_fetch_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU sequencing definitions: state encoding, default widths/opcodes and
// the program-byte layout used by the fetch and accumulator blocks.
package fetch_sequencer_pkg;

  localparam int unsigned PC_W_DEF    = 12;
  localparam logic [3:0]  HALT_OP_DEF = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [3:0] instr;
    logic [3:0] oprnd;
  } prog_byte_t;

  // Upper nibble is the opcode, lower nibble the operand.
  function automatic prog_byte_t split_byte(input logic [7:0] b);
    return prog_byte_t'(b);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its environment (program ROM, jump
// source, execute-phase consumers).
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
);

  logic            en;
  logic            rom_valid;
  logic [7:0]      prog_byte;
  logic            load_pc;
  logic [PC_W-1:0] pc_in;

  logic [PC_W-1:0] pc;
  logic [3:0]      instr;
  logic [3:0]      oprnd;
  logic            fetch_en;
  logic            acc_en;
  logic            phase;
  logic            halted;

  modport master (
    output en, rom_valid, prog_byte, load_pc, pc_in,
    input  pc, instr, oprnd, fetch_en, acc_en, phase, halted
  );

  modport slave (
    input  en, rom_valid, prog_byte, load_pc, pc_in,
    output pc, instr, oprnd, fetch_en, acc_en, phase, halted
  );

endinterface

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter register with load (jump), increment and hold; arithmetic
// wraps modulo 2^PC_W with no carry out.
module pc_counter
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Load wins over increment; the sequencer never requests both at once.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: steps IDLE -> FETCH -> EXEC, captures the program
// byte, drives the PC counter and stops permanently on the halt opcode.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter logic [3:0]  HALT_OP = HALT_OP_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  fetch_sequencer_if.slave   bus
);

  seq_state_e      state_q;
  logic [3:0]      instr_q;
  logic [3:0]      oprnd_q;
  logic            phase_q;
  logic            halted_q;

  logic            fetch_en;
  logic            acc_en;
  logic            pc_load;
  logic            is_halt_op;
  logic [PC_W-1:0] pc;
  prog_byte_t      fetched;

  assign fetched    = split_byte(bus.prog_byte);
  assign is_halt_op = (instr_q == HALT_OP);

  // Strobes are decoded from the current state only, so they are one-hot by
  // construction and both fall to zero whenever EN is low.
  always_comb begin
    fetch_en = 1'b0;
    acc_en   = 1'b0;
    pc_load  = 1'b0;
    case (state_q)
      ST_FETCH: fetch_en = bus.en & bus.rom_valid;
      ST_EXEC: begin
        acc_en  = bus.en & ~is_halt_op;
        pc_load = acc_en & bus.load_pc;
      end
      default: ;
    endcase
  end

  pc_counter #(
    .PC_W (PC_W)
  ) u_pc (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .inc_i      (fetch_en),
    .load_i     (pc_load),
    .load_val_i (bus.pc_in),
    .pc_o       (pc)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      instr_q  <= 4'h0;
      oprnd_q  <= 4'h0;
      phase_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (bus.en) begin
      case (state_q)
        ST_IDLE: state_q <= ST_FETCH;
        ST_FETCH: begin
          if (fetch_en) begin
            instr_q <= fetched.instr;
            oprnd_q <= fetched.oprnd;
            state_q <= ST_EXEC;
            phase_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          phase_q <= 1'b0;
          if (is_halt_op) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q  <= ST_FETCH;
          end
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign bus.pc       = pc;
  assign bus.instr    = instr_q;
  assign bus.oprnd    = oprnd_q;
  assign bus.fetch_en = fetch_en;
  assign bus.acc_en   = acc_en;
  assign bus.phase    = phase_q;
  assign bus.halted   = halted_q;

  a_strobe_exclusive : assert property (@(posedge CLK) disable iff (!RESET)
    !(fetch_en && acc_en));

  a_halt_sticky : assert property (@(posedge CLK) disable iff (!RESET)
    halted_q |=> halted_q);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + randomized bench for fetch_sequencer against a behavioural
// instruction-level model.
module tb_fetch_sequencer;

  logic clk;
  logic rst_n;

  int n_chk = 0;
  int n_err = 0;

  fetch_sequencer_if #(.PC_W(12)) bus ();

  fetch_sequencer #(.PC_W(12), .HALT_OP(4'hF)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: where the machine is in the instruction cycle.
  typedef enum int { M_IDLE, M_FETCH, M_EXEC, M_HALT } mstage_t;
  mstage_t    m_stage;
  logic [11:0] m_pc;
  logic [3:0]  m_ins;
  logic [3:0]  m_op;

  function automatic void model_reset();
    m_stage = M_IDLE;
    m_pc    = 12'h000;
    m_ins   = 4'h0;
    m_op    = 4'h0;
  endfunction

  function automatic void model_clock();
    if (!bus.en) return;
    if (m_stage == M_IDLE) begin
      m_stage = M_FETCH;
    end else if (m_stage == M_FETCH) begin
      if (bus.rom_valid) begin
        m_ins   = bus.prog_byte[7:4];
        m_op    = bus.prog_byte[3:0];
        m_pc    = m_pc + 12'd1;
        m_stage = M_EXEC;
      end
    end else if (m_stage == M_EXEC) begin
      if (m_ins == 4'hF) begin
        m_stage = M_HALT;
      end else begin
        if (bus.load_pc) m_pc = bus.pc_in;
        m_stage = M_FETCH;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic e_fetch;
    logic e_acc;
    e_fetch = (m_stage == M_FETCH) && bus.en && bus.rom_valid;
    e_acc   = (m_stage == M_EXEC) && bus.en && (m_ins != 4'hF);
    chk({tag, ".pc"},       32'(bus.pc),       32'(m_pc));
    chk({tag, ".instr"},    32'(bus.instr),    32'(m_ins));
    chk({tag, ".oprnd"},    32'(bus.oprnd),    32'(m_op));
    chk({tag, ".phase"},    32'(bus.phase),    32'(m_stage == M_EXEC));
    chk({tag, ".halted"},   32'(bus.halted),   32'(m_stage == M_HALT));
    chk({tag, ".fetch_en"}, 32'(bus.fetch_en), 32'(e_fetch));
    chk({tag, ".acc_en"},   32'(bus.acc_en),   32'(e_acc));
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    logic [11:0] frozen_pc;
    rst_n         = 1'b0;
    bus.en        = 1'b1;
    bus.rom_valid = 1'b1;
    bus.prog_byte = 8'hA4;
    bus.load_pc   = 1'b0;
    bus.pc_in     = 12'h000;
    model_reset();

    // Reset with EN=1, first instruction A4.
    @(posedge clk);
    #1;
    check_all("rst");
    rst_n = 1'b1;
    step("idle");
    chk("a4.fetch_pulse", 32'(bus.fetch_en), 32'd1);
    step("a4.fetch");
    chk("a4.instr", 32'(bus.instr), 32'hA);
    chk("a4.oprnd", 32'(bus.oprnd), 32'h4);
    chk("a4.pc", 32'(bus.pc), 32'h001);
    chk("a4.acc_en", 32'(bus.acc_en), 32'd1);

    // Jump in EXEC, then a jump request in FETCH that must be ignored.
    bus.load_pc = 1'b1;
    bus.pc_in   = 12'h3C0;
    step("jmp.exec");
    chk("jmp.pc", 32'(bus.pc), 32'h3C0);
    bus.prog_byte = 8'h12;
    bus.pc_in     = 12'h555;
    step("jmp.fetch");
    chk("jmp.ignored", 32'(bus.pc), 32'h3C1);
    bus.load_pc = 1'b0;
    step("exec12");

    // ROM wait states.
    bus.rom_valid = 1'b0;
    bus.prog_byte = 8'h35;
    for (int i = 0; i < 3; i++) begin
      step("wait");
      chk("wait.pc", 32'(bus.pc), 32'h3C1);
      chk("wait.instr", 32'(bus.instr), 32'h1);
    end
    chk("wait.fetch_en", 32'(bus.fetch_en), 32'd0);
    bus.rom_valid = 1'b1;
    step("wait.done");
    chk("wait.cap", 32'(bus.instr), 32'h3);
    chk("wait.pc2", 32'(bus.pc), 32'h3C2);

    // Wrap from FFF to 000.
    bus.load_pc = 1'b1;
    bus.pc_in   = 12'hFFF;
    step("wrap.jmp");
    bus.load_pc = 1'b0;
    step("wrap.fetch");
    chk("wrap.pc", 32'(bus.pc), 32'h000);

    // EN dropped for two cycles in EXEC.
    bus.en = 1'b0;
    step("en0.a");
    step("en0.b");
    chk("en0.phase", 32'(bus.phase), 32'd1);
    bus.en = 1'b1;
    #1;
    chk("en1.acc_en", 32'(bus.acc_en), 32'd1);
    step("en1");

    // Randomized run, halt opcode excluded.
    for (int i = 0; i < 120; i++) begin
      bus.en        = ($urandom_range(0, 3) != 0);
      bus.rom_valid = ($urandom_range(0, 2) != 0);
      bus.prog_byte = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
      bus.load_pc   = $urandom_range(0, 1) == 1;
      bus.pc_in     = 12'($urandom);
      step("rnd");
    end

    // Halt: fetch F0 and freeze.
    bus.en        = 1'b1;
    bus.rom_valid = 1'b1;
    bus.prog_byte = 8'hF0;
    bus.load_pc   = 1'b1;
    bus.pc_in     = 12'h123;
    for (int i = 0; i < 8 && m_stage != M_HALT; i++) begin
      if (m_stage == M_EXEC) chk("halt.acc_en", 32'(bus.acc_en), 32'd0);
      step("to_halt");
    end
    chk("halt.reached", 32'(bus.halted), 32'd1);
    frozen_pc = m_pc;
    for (int i = 0; i < 10; i++) begin
      bus.pc_in = 12'($urandom);
      step("halted");
      chk("halt.pc", 32'(bus.pc), 32'(frozen_pc));
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("halt.rst_halted", 32'(bus.halted), 32'd0);
    chk("halt.rst_pc", 32'(bus.pc), 32'h000);

    // Reset mid-fetch must not leave a partial update.
    @(posedge clk);
    #1;
    bus.load_pc   = 1'b0;
    bus.prog_byte = 8'h5A;
    rst_n         = 1'b1;
    step("ab.idle");
    chk("ab.fetching", 32'(bus.fetch_en), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("ab.rst");

    // Stay in IDLE until the first edge with EN=1.
    bus.en = 1'b0;
    rst_n  = 1'b1;
    step("idle.en0a");
    step("idle.en0b");
    bus.en = 1'b1;
    step("idle.go");
    chk("idle.fetch", 32'(bus.fetch_en), 32'd1);
    step("idle.fetch");
    chk("idle.instr", 32'(bus.instr), 32'h5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
